mem_slave_param: RTL and testbench
==================================

// Module: mem_slave_param
// PURPOSE
// Parametrised single-port memory-mapped RAM slave for the SystemC BFM sample benches. It services
// one cs/rw request at a time through a single-cycle ready pulse, with configurable wait states,
// byte-enabled writes and an out-of-range error. It sits directly under the BFM-driven top level.
// PARAMETERS
// ADDR_W      16     byte-address width
// DATA_W      32     data width; multiple of 8, power of two, >= 8
// DEPTH       16384  RAM depth in words; 1..2**(ADDR_W-LSB), LSB = log2(DATA_W/8)
// WAIT_CYCLES 0      extra wait states before ready; 0..255
// PORTS
// clk       in   1         clock; all logic on rising edge
// reset     in   1         asynchronous, active-high reset
// addr      in   ADDR_W    byte address; word index = addr[ADDR_W-1:LSB], low LSB bits ignored
// cs        in   1         request; held high by the master until ready is seen
// rw        in   1         1 = read, 0 = write
// byte_en   in   DATA_W/8  write byte lanes; bit i covers data_in[8i+7:8i]; ignored on reads
// data_in   in   DATA_W    write data
// ready     out  1         one-cycle completion pulse
// err       out  1         one-cycle pulse coincident with ready; address out of range
// data_out  out  DATA_W    read data; valid only in the ready cycle, otherwise 0
// BEHAVIOUR
// - Reset (async assert, sync release): state=IDLE, wait counter=0, ready=0, err=0, data_out=0.
//   RAM contents are not reset and not initialised.
// - FSM states: IDLE, WAIT, ACCESS, DONE. cs=0 sampled in any state -> IDLE next cycle (abort).
//   IDLE  : cs=1 -> ACCESS if WAIT_CYCLES=0, else WAIT with counter=WAIT_CYCLES-1.
//   WAIT  : counter=0 -> ACCESS; else decrement.
//   ACCESS: perform access; set ready=1 (registered); -> DONE.
//   DONE  : stay while cs=1. No new access until cs has been sampled low at least once.
// - Latency: cs first sampled high at edge N -> ready=1 for exactly one cycle after edge
//   N+1+WAIT_CYCLES. With WAIT_CYCLES=0 this is edge N+1.
// - addr, rw, byte_en and data_in are sampled at the edge leaving ACCESS. The master holds them stable
//   from cs rise until ready.
// - Read: data_out <= ram[idx] in the same edge as ready. Write: ram[idx] byte lanes with byte_en=1
//   updated and other lanes kept; data_out stays 0. byte_en=0 gives a valid no-op write with ready.
// - Out of range (idx >= DEPTH): ready=1 and err=1 together; no RAM write; data_out=0.
// - Outside the ready cycle: ready=0, err=0, data_out=0.
// - Abort: cs dropped in WAIT or IDLE means no RAM access, no ready. cs dropped in the same cycle
//   ACCESS is sampled still completes the access: ACCESS does not test cs; the FSM then goes to IDLE.
// - Reset during WAIT/ACCESS: the access is discarded, no write happens, and the outputs clear at once.
// - Back-to-back: cs low for 1 cycle after ready, then high -> a new request is accepted normally.
// - Index arithmetic is unsigned ADDR_W-LSB bits, with no wrap-around. Out-of-range addresses are
//   never aliased.
// TESTING
// T1 W=0: write 0xDEADBEEF @0x0010 be=0xF, then read @0x0010 -> ready 1 cycle after cs sampled,
//    data_out=0xDEADBEEF for 1 cycle then 0.
// T2 byte_en: write 0x11223344 @0x20 be=0xF, then 0xAABBCCDD be=0x5, read -> 0x11BB33DD.
// T3 WAIT_CYCLES=3: read -> ready exactly 4 cycles after cs first sampled high; ready 1 cycle.
// T4 DEPTH=1024, read/write @byte 0x1000 -> ready=1, err=1, data_out=0; word 0 unchanged.
// T5 WAIT_CYCLES=3, write, drop cs after 2 cycles -> no ready; read back shows old data.
// T6 reset pulsed mid-WAIT -> ready/err/data_out 0 at once; next request completes with normal
//    latency; hold cs after ready -> no second ready.

Source files
------------

// File: rtl/mem_slave_param.sv
// Single-port memory-mapped RAM slave: one cs/rw request at a time, optional wait states,
// byte-enabled writes, one-cycle ready pulse with err for out-of-range word indices.
module mem_slave_param #(
  parameter int ADDR_W      = 16,
  parameter int DATA_W      = 32,
  parameter int DEPTH       = 16384,
  parameter int WAIT_CYCLES = 0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ADDR_W-1:0]     addr,
  input  logic                  cs,
  input  logic                  rw,
  input  logic [DATA_W/8-1:0]   byte_en,
  input  logic [DATA_W-1:0]     data_in,
  output logic                  ready,
  output logic                  err,
  output logic [DATA_W-1:0]     data_out
);

  localparam int NB  = DATA_W / 8;
  localparam int LSB = $clog2(NB);
  localparam int IW  = ADDR_W - LSB;
  localparam int AW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [IW:0] DEPTH_L   = (IW+1)'(DEPTH);
  localparam logic [7:0]  WAIT_INIT = (WAIT_CYCLES > 0) ? 8'(WAIT_CYCLES - 1) : 8'd0;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACCESS, S_DONE} state_t;

  state_t            state_q, state_d;
  logic [7:0]        cnt_q, cnt_d;
  logic              ready_q, ready_d;
  logic              err_q, err_d;
  logic              rd_q, rd_d;
  logic [DATA_W-1:0] rdata_q;

  logic [DATA_W-1:0] ram [DEPTH];

  logic [IW-1:0] idx;
  logic [AW-1:0] ram_addr;
  logic          in_range;
  logic          access;

  assign idx      = addr[ADDR_W-1:LSB];
  assign ram_addr = idx[AW-1:0];
  // Full-width compare so indices past DEPTH never alias onto low words.
  assign in_range = ({1'b0, idx} < DEPTH_L);
  assign access   = (state_q == S_ACCESS);

  generate
    if (LSB > 0) begin : g_lsb
      logic addr_lsb_unused;
      assign addr_lsb_unused = ^addr[LSB-1:0];
    end
  endgenerate

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ready_d = 1'b0;
    err_d   = 1'b0;
    rd_d    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (cs) begin
          if (WAIT_CYCLES == 0) begin
            state_d = S_ACCESS;
          end else begin
            state_d = S_WAIT;
            cnt_d   = WAIT_INIT;
          end
        end
      end
      S_WAIT: begin
        if (!cs) begin
          state_d = S_IDLE;
        end else if (cnt_q == 8'd0) begin
          state_d = S_ACCESS;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      S_ACCESS: begin
        // The access completes even if cs fell this cycle; only the return path depends on cs.
        ready_d = 1'b1;
        err_d   = !in_range;
        rd_d    = rw && in_range;
        state_d = cs ? S_DONE : S_IDLE;
      end
      S_DONE: begin
        if (!cs) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= 8'd0;
      ready_q <= 1'b0;
      err_q   <= 1'b0;
      rd_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ready_q <= ready_d;
      err_q   <= err_d;
      rd_q    <= rd_d;
    end
  end

  always_ff @(posedge clk) begin
    if (access && in_range) begin
      if (rw) begin
        rdata_q <= ram[ram_addr];
      end else begin
        for (int i = 0; i < NB; i++) begin
          if (byte_en[i]) ram[ram_addr][8*i +: 8] <= data_in[8*i +: 8];
        end
      end
    end
  end

  assign ready    = ready_q;
  assign err      = err_q;
  assign data_out = rd_q ? rdata_q : '0;

endmodule

// File: tb/tb_mem_slave_param.sv
// Directed bench: a zero-wait slave and a three-wait slave (both 1024 words) share the bus;
// cs is steered to one of them per request.
module tb_mem_slave_param;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] addr;
  logic        cs, rw, sel;
  logic [3:0]  byte_en;
  logic [31:0] data_in;
  logic        cs0, cs3, ready0, ready3, err0, err3;
  logic [31:0] dout0, dout3;
  logic        rdy, er;
  logic [31:0] dout;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  assign cs0  = cs & ~sel;
  assign cs3  = cs & sel;
  assign rdy  = sel ? ready3 : ready0;
  assign er   = sel ? err3   : err0;
  assign dout = sel ? dout3  : dout0;

  mem_slave_param #(.ADDR_W(16), .DATA_W(32), .DEPTH(1024), .WAIT_CYCLES(0)) dut0 (
    .clk(clk), .reset(reset), .addr(addr), .cs(cs0), .rw(rw), .byte_en(byte_en),
    .data_in(data_in), .ready(ready0), .err(err0), .data_out(dout0));

  mem_slave_param #(.ADDR_W(16), .DATA_W(32), .DEPTH(1024), .WAIT_CYCLES(3)) dut3 (
    .clk(clk), .reset(reset), .addr(addr), .cs(cs3), .rw(rw), .byte_en(byte_en),
    .data_in(data_in), .ready(ready3), .err(err3), .data_out(dout3));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Issues one request; expects ready after exp_cyc edges following the edge that first samples cs.
  // cs is held three more cycles after ready (no second pulse allowed), then dropped for one edge.
  task automatic req(input logic which, input logic read, input logic [15:0] a,
                     input logic [3:0] be, input logic [31:0] d, input int exp_cyc,
                     input logic exp_err, input logic [31:0] exp_data, input string tag);
    int cycles;
    int extra;
    logic got, got_err;
    logic [31:0] got_data;
    sel = which; rw = read; addr = a; byte_en = be; data_in = d; cs = 1'b1;
    @(posedge clk);
    cycles = 0; got = 1'b0; got_err = 1'b0; got_data = '0;
    while (!got && cycles < 20) begin
      @(posedge clk);
      cycles++;
      #1;
      if (rdy) begin
        got = 1'b1; got_err = er; got_data = dout;
      end
    end
    chk({tag, "_latency"}, cycles, exp_cyc);
    chk({tag, "_err"}, {31'd0, got_err}, {31'd0, exp_err});
    chk({tag, "_data"}, got_data, exp_data);
    extra = 0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      if (rdy) extra++;
      if (i == 0) chk({tag, "_data_after"}, dout, 32'h0);
    end
    chk({tag, "_extra_ready"}, extra, 0);
    cs = 1'b0;
    @(posedge clk); #1;
  endtask

  initial begin
    int pulses;
    reset = 1'b1; cs = 1'b0; sel = 1'b0; rw = 1'b0;
    addr = '0; byte_en = '0; data_in = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready0", {31'd0, ready0}, 32'd0);
    chk("rst_err0",   {31'd0, err0},   32'd0);
    chk("rst_dout0",  dout0,           32'h0);
    chk("rst_ready3", {31'd0, ready3}, 32'd0);
    reset = 1'b0;
    @(posedge clk); #1;

    // T1: zero-wait write then read
    req(0, 0, 16'h0010, 4'hF, 32'hDEADBEEF, 1, 0, 32'h0, "t1_wr");
    req(0, 1, 16'h0010, 4'h0, 32'h0, 1, 0, 32'hDEADBEEF, "t1_rd");

    // T2: byte lanes, including an all-lanes-off no-op write
    req(0, 0, 16'h0020, 4'hF, 32'h11223344, 1, 0, 32'h0, "t2_wr_full");
    req(0, 0, 16'h0020, 4'h5, 32'hAABBCCDD, 1, 0, 32'h0, "t2_wr_be5");
    req(0, 1, 16'h0020, 4'h0, 32'h0, 1, 0, 32'h11BB33DD, "t2_rd");
    req(0, 0, 16'h0020, 4'h0, 32'h99999999, 1, 0, 32'h0, "t2_wr_be0");
    req(0, 1, 16'h0020, 4'h0, 32'h0, 1, 0, 32'h11BB33DD, "t2_rd_be0");

    // T3: three wait states
    req(1, 0, 16'h0040, 4'hF, 32'hCAFEF00D, 4, 0, 32'h0, "t3_wr");
    req(1, 1, 16'h0040, 4'h0, 32'h0, 4, 0, 32'hCAFEF00D, "t3_rd");

    // T4: index 1023 is the last valid word; byte 0x1000 (index 1024) must not alias word 0
    req(0, 0, 16'h0000, 4'hF, 32'h01020304, 1, 0, 32'h0, "t4_wr_w0");
    req(0, 0, 16'h0FFC, 4'hF, 32'h0BADCAFE, 1, 0, 32'h0, "t4_wr_last");
    req(0, 1, 16'h0FFC, 4'h0, 32'h0, 1, 0, 32'h0BADCAFE, "t4_rd_last");
    req(0, 0, 16'h1000, 4'hF, 32'hFFFFFFFF, 1, 1, 32'h0, "t4_wr_oor");
    req(0, 1, 16'h1000, 4'h0, 32'h0, 1, 1, 32'h0, "t4_rd_oor");
    req(0, 1, 16'h0000, 4'h0, 32'h0, 1, 0, 32'h01020304, "t4_rd_w0");

    // T5: write aborted in WAIT leaves memory untouched
    sel = 1'b1; rw = 1'b0; addr = 16'h0040; byte_en = 4'hF; data_in = 32'h55555555; cs = 1'b1;
    @(posedge clk);
    @(posedge clk); #1;
    cs = 1'b0;
    pulses = 0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      if (ready3) pulses++;
    end
    chk("t5_abort_ready", pulses, 0);
    req(1, 1, 16'h0040, 4'h0, 32'h0, 4, 0, 32'hCAFEF00D, "t5_rd");

    // T6: reset mid-WAIT, then a normal request with held cs
    sel = 1'b1; rw = 1'b1; addr = 16'h0040; byte_en = 4'h0; cs = 1'b1;
    @(posedge clk);
    @(posedge clk); #1;
    reset = 1'b1; #1;
    chk("t6_wait_rst_ready", {31'd0, ready3}, 32'd0);
    chk("t6_wait_rst_dout",  dout3,           32'h0);
    cs = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
    req(1, 1, 16'h0040, 4'h0, 32'h0, 4, 0, 32'hCAFEF00D, "t6_rd");

    // Reset landing in the ready cycle must clear outputs without waiting for a clock edge
    sel = 1'b0; rw = 1'b1; addr = 16'h0010; byte_en = 4'h0; cs = 1'b1;
    @(posedge clk);
    @(posedge clk); #1;
    chk("t6_pre_ready", {31'd0, ready0}, 32'd1);
    chk("t6_pre_dout",  dout0,           32'hDEADBEEF);
    #2 reset = 1'b1; #1;
    chk("t6_async_ready", {31'd0, ready0}, 32'd0);
    chk("t6_async_dout",  dout0,           32'h0);
    cs = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
    req(0, 1, 16'h0010, 4'h0, 32'h0, 1, 0, 32'hDEADBEEF, "t6_rd_after");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
